// File: rtl/wr_addr_pkg.sv
// Shared encodings for the write-address sequencer: target/kernel selects, FSM states, kernel lengths.
// Pure declarations, no logic or latency.
package wr_addr_pkg;

  localparam logic TGT_KW   = 1'b0;
  localparam logic TGT_IFMD = 1'b1;

  localparam logic [1:0] KSEL_1X1 = 2'b00;
  localparam logic [1:0] KSEL_3X3 = 2'b01;
  localparam logic [1:0] KSEL_5X5 = 2'b10;
  localparam logic [1:0] KSEL_7X7 = 2'b11;

  localparam int KSEG = 49;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [5:0] k_len(input logic [1:0] ksel);
    logic [5:0] len;
    case (ksel)
      KSEL_1X1: len = 6'd1;
      KSEL_3X3: len = 6'd9;
      KSEL_5X5: len = 6'd25;
      default:  len = 6'd49;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/wr_addr_idx_cnt.sv
// Nested word-index / channel counter; idx wraps at i_len_m1 and bumps ch. Zero latency on o_wrap,
// counts only when i_en, holds otherwise; i_clr restarts at (0,0).
module wr_addr_idx_cnt #(
  parameter int IDX_W = 6,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_len_m1,
  output logic [IDX_W-1:0] o_idx,
  output logic [CH_W-1:0]  o_ch,
  output logic             o_wrap
);

  logic [IDX_W-1:0] r_idx;
  logic [CH_W-1:0]  r_ch;

  assign o_idx  = r_idx;
  assign o_ch   = r_ch;
  assign o_wrap = (r_idx == i_len_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_ch  <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
      r_ch  <= '0;
    end else if (i_en) begin
      if (o_wrap) begin
        r_idx <= '0;
        r_ch  <= r_ch + 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_addr_seq_gen.sv
// Multi-channel SRAM write-address sequencer; wr_en/wr_addr/wr_last combinational per accepted beat, done 1 cycle after last.
// No backpressure: in_valid gates each write. Optional sticky err port under WR_ADDR_ERR_EN.
module wr_addr_seq_gen
  import wr_addr_pkg::*;
#(
  parameter int MAX_CH     = 4,
  parameter int IFMD_DEPTH = 64,
  parameter int KMAX       = 7,
  parameter int CH_W       = (MAX_CH > 1) ? $clog2(MAX_CH) : 1,
  parameter int ADDR_W     = $clog2(MAX_CH * ((IFMD_DEPTH > KMAX*KMAX) ? IFMD_DEPTH : KMAX*KMAX))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_st,
  input  logic              tgt,
  input  logic [1:0]        ksel,
  input  logic [CH_W-1:0]   num_ch,
  input  logic              in_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_ch,
  output logic              wr_last,
  output logic              done,
  output logic              busy
`ifdef WR_ADDR_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int SEG_K   = KMAX * KMAX;
  localparam int SEG_MAX = (IFMD_DEPTH > SEG_K) ? IFMD_DEPTH : SEG_K;
  localparam int IDX_W   = $clog2(SEG_MAX);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(MAX_CH - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_tgt;
  logic [1:0]        r_ksel;
  logic [CH_W-1:0]   r_num_ch;

  logic              w_wr_en;
  logic              w_wrap;
  logic              w_last;
  logic [IDX_W-1:0]  w_len_m1;
  logic [IDX_W-1:0]  w_idx;
  logic [CH_W-1:0]   w_ch;
  logic [ADDR_W-1:0] w_seg;
  logic [CH_W-1:0]   w_num_ch_clamp;

  // A start pulse always wins over the beat presented in the same cycle.
  assign w_wr_en  = r_busy & in_valid & ~in_st;
  assign w_len_m1 = (r_tgt == TGT_IFMD) ? IDX_W'(IFMD_DEPTH - 1) : IDX_W'(k_len(r_ksel) - 6'd1);
  assign w_seg    = (r_tgt == TGT_IFMD) ? ADDR_W'(IFMD_DEPTH) : ADDR_W'(SEG_K);
  assign w_last   = w_wrap & (w_ch == r_num_ch);
  assign w_num_ch_clamp = (32'(num_ch) > 32'(MAX_CH - 1)) ? CH_MAX : num_ch;

  wr_addr_idx_cnt #(
    .IDX_W (IDX_W),
    .CH_W  (CH_W)
  ) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (in_st),
    .i_en     (w_wr_en),
    .i_len_m1 (w_len_m1),
    .o_idx    (w_idx),
    .o_ch     (w_ch),
    .o_wrap   (w_wrap)
  );

  assign wr_en   = w_wr_en;
  assign wr_last = w_wr_en & w_last;
  assign wr_addr = ADDR_W'(w_ch) * w_seg + ADDR_W'(w_idx);
  assign wr_ch   = w_ch;
  assign done    = r_done;
  assign busy    = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tgt    <= 1'b0;
      r_ksel   <= '0;
      r_num_ch <= '0;
    end else begin
      r_done <= 1'b0;
      if (in_st) begin
        r_state  <= RUN;
        r_busy   <= 1'b1;
        r_tgt    <= tgt;
        r_ksel   <= ksel;
        r_num_ch <= w_num_ch_clamp;
      end else if (r_state == RUN && w_wr_en && w_last) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

`ifdef WR_ADDR_ERR_EN
  logic r_err;
  assign err = r_err;

  // Stray beats while idle and aborts mid-run are latched until the next clean start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (in_st && r_state == IDLE) begin
      r_err <= 1'b0;
    end else if ((in_st && r_state == RUN) || (in_valid && r_state == IDLE)) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_addr_seq_gen.sv
// Randomized + directed scoreboard bench for wr_addr_seq_gen; model lists every transfer's beats up front.
module tb_wr_addr_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_st = 1'b0;
  logic       tgt = 1'b0;
  logic [1:0] ksel = 2'b00;
  logic [1:0] num_ch = 2'b00;
  logic       in_valid = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [1:0] wr_ch;
  logic       wr_last;
  logic       done;
  logic       busy;
`ifdef WR_ADDR_ERR_EN
  logic       err;
`endif

  wr_addr_seq_gen dut (
    .clk      (clk),
    .rst      (rst),
    .in_st    (in_st),
    .tgt      (tgt),
    .ksel     (ksel),
    .num_ch   (num_ch),
    .in_valid (in_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_ch    (wr_ch),
    .wr_last  (wr_last),
    .done     (done),
    .busy     (busy)
`ifdef WR_ADDR_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int ch;
    bit last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t m_pend[$];
  beat_t exp_q[$];
  bit    m_busy = 0, m_done = 0, m_err = 0;
  bit    cur_busy = 0, cur_done = 0, cur_wen = 0, cur_err = 0;
  bit    mon_en = 0;
  beat_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-transfer beat list: channel-major, kernel edge 2*ksel+1, ifmap segment 64 words.
  task automatic load(input bit t, input logic [1:0] k, input int nc);
    int edge_len, len, seg;
    m_pend.delete();
    edge_len = 2 * int'(k) + 1;
    len = t ? 64 : edge_len * edge_len;
    seg = t ? 64 : 49;
    if (nc > 3) nc = 3;
    for (int c = 0; c <= nc; c++)
      for (int i = 0; i < len; i++)
        m_pend.push_back('{addr: c * seg + i, ch: c, last: (c == nc) && (i == len - 1)});
  endtask

  task automatic step(input bit st, input bit v);
    beat_t e;
    e = '{addr: 0, ch: 0, last: 1'b0};
    in_st = st;
    in_valid = v;
    cur_busy = m_busy;
    cur_done = m_done;
    cur_err  = m_err;
    cur_wen  = m_busy && v && !st;
    if (st && !m_busy) m_err = 0;
    else if ((st && m_busy) || (v && !m_busy)) m_err = 1;
    m_done = 0;
    if (cur_wen && m_pend.size() > 0) begin
      e = m_pend.pop_front();
      exp_q.push_back(e);
    end
    if (st) begin
      m_busy = 1;
      load(tgt, ksel, int'(num_ch));
    end else if (cur_wen && e.last) begin
      m_busy = 0;
      m_done = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_busy = 0; m_done = 0; m_err = 0;
    m_pend.delete();
    cur_busy = 0; cur_done = 0; cur_wen = 0; cur_err = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    @(posedge clk);
    #1;
    in_st = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, cur_busy);
      chk("done", done, cur_done);
      chk("wr_en", wr_en, cur_wen);
`ifdef WR_ADDR_ERR_EN
      chk("err", err, cur_err);
`endif
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=%0d expected=none at %0t", wr_addr, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_ch", wr_ch, mon_e.ch);
          chk("wr_last", wr_last, mon_e.last);
        end
      end else begin
        chk("wr_last_idle", wr_last, 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int guard;
    bit st;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_ch", wr_ch, 0);
    chk("reset_wr_last", wr_last, 0);
    rst = 1'b1;
    mon_en = 1;

    // 3x3 kernels, two channels, continuous valid
    tgt = 0; ksel = 2'd1; num_ch = 2'd1;
    step(1, 0);
    repeat (18) step(0, 1);
    step(0, 0); step(0, 0);

    // ifmap, four channels, valid toggling
    tgt = 1; num_ch = 2'd3;
    step(1, 0);
    for (int i = 0; i < 512; i++) step(0, (i % 2) == 0);
    step(0, 0); step(0, 0);

    // 7x7 aborted after 20 beats by a 1x1 restart
    tgt = 0; ksel = 2'd3; num_ch = 2'd0;
    step(1, 0);
    repeat (20) step(0, 1);
    ksel = 2'd0;
    step(1, 1);
    step(0, 1);
    step(0, 0); step(0, 0);

    // restart on the last-beat cycle
    ksel = 2'd0;
    step(1, 0);
    step(1, 1);
    step(0, 1);
    step(0, 0); step(0, 0);

    // 5x5 restarted in the done cycle
    ksel = 2'd2;
    step(1, 0);
    repeat (25) step(0, 1);
    step(1, 0);
    repeat (25) step(0, 1);
    step(0, 0); step(0, 0);

    // reset mid ifmap run at idx 30
    tgt = 1; num_ch = 2'd0;
    step(1, 0);
    repeat (30) step(0, 1);
    in_valid = 1'b1;
    do_reset();
    step(1, 0);
    repeat (64) step(0, 1);
    step(0, 0);

    // stray valid while idle, then a clean start
    step(0, 1);
    step(0, 0); step(0, 0);
    tgt = 0; ksel = 2'd0;
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0); step(0, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      st = ($urandom_range(0, 39) == 0);
      if (st) begin
        tgt    = ($urandom_range(0, 3) == 0);
        ksel   = 2'($urandom_range(0, 3));
        num_ch = 2'($urandom_range(0, 3));
      end
      step(st, $urandom_range(0, 3) != 0);
    end

    guard = 0;
    while (m_busy && guard < 2000) begin
      step(0, 1);
      guard++;
    end
    chk("drain_timeout", guard < 2000, 1);
    step(0, 0); step(0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
